sdram_dot_master: RTL and testbench

//  Avalon-MM read master computing NUM_NEURONS dot products of one VEC_LEN-pixel image against
//  row-major weight rows. Sits between the HPS start/done handshake and the SDRAM/on-chip bridge.
//  One result per neuron is streamed out with a valid pulse.

---
 rtl/sdram_dot_pkg.sv | 22 ++
 rtl/dot_mac.sv | 22 ++
 rtl/sdram_dot_master.sv | 186 ++++++++++++++++++
 tb/tb_sdram_dot_master.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_dot_pkg.sv
`default_nettype none
// sdram_dot_pkg: shared state encoding and Avalon addressing helper for sdram_dot_master.
package sdram_dot_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_RD_PIX = 4'd1,
    S_WT_PIX = 4'd2,
    S_RD_WGT = 4'd3,
    S_WT_WGT = 4'd4,
    S_ACC    = 4'd5,
    S_EMIT   = 4'd6,
    S_DONE   = 4'd7
  } state_t;

  // Byte distance between consecutive DATA_W-wide elements on the byte-addressed bus.
  function automatic int unsigned avalon_stride(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dot_mac.sv
`default_nettype none
// dot_mac: combinational signed multiply-accumulate of an unsigned pixel and a signed weight.
module dot_mac #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic [DATA_W-1:0] pix,
  input  logic [DATA_W-1:0] wgt,
  input  logic [ACC_W-1:0]  acc_in,
  output logic [ACC_W-1:0]  acc_out
);

  logic signed [2*DATA_W:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;

  // Pixel gets a zero sign bit so the product is a true unsigned x signed result.
  assign prod     = $signed({1'b0, pix}) * $signed({wgt[DATA_W-1], wgt});
  assign prod_ext = ACC_W'(prod);
  assign acc_out  = acc_in + prod_ext;

endmodule
`default_nettype wire

// File: rtl/sdram_dot_master.sv
`default_nettype none
// sdram_dot_master: Avalon-MM read master producing NUM_NEURONS signed dot products of one image.
// Optional build macro SKIP_ZERO_EN: zero pixels skip their weight read and accumulate.
module sdram_dot_master
  import sdram_dot_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 32,
  parameter int                VEC_LEN     = 784,
  parameter int                NUM_NEURONS = 10,
  parameter int                ACC_W       = 40,
  parameter logic [ADDR_W-1:0] PIX_BASE    = '0,
  parameter logic [ADDR_W-1:0] WGT_BASE    = ADDR_W'(32'h0400_0000)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           startSig,
  output logic                           doneSig,
  output logic                           read_n,
  output logic                           write_n,
  output logic                           chipselect,
  output logic [DATA_W/8-1:0]            byteenable,
  output logic [ADDR_W-1:0]              address,
  input  logic                           waitrequest,
  input  logic                           readdatavalid,
  input  logic [DATA_W-1:0]              readdata,
  output logic [ACC_W-1:0]               result,
  output logic [$clog2(NUM_NEURONS):0]   result_idx,
  output logic                           result_valid,
  output logic [3:0]                     s
);

  localparam int                IW     = $clog2(VEC_LEN + 1);
  localparam int                NW     = $clog2(NUM_NEURONS) + 1;
  localparam logic [IW-1:0]     I_LAST = IW'(VEC_LEN - 1);
  localparam logic [NW-1:0]     N_LAST = NW'(NUM_NEURONS - 1);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(avalon_stride(DATA_W));

  state_t            state;
  logic [IW-1:0]     i;
  logic [NW-1:0]     n;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  mac_out;
  logic [DATA_W-1:0] pix;
  logic [DATA_W-1:0] wgt;
  logic [ADDR_W-1:0] pix_addr_next;
  logic [ADDR_W-1:0] wgt_addr;
  logic              last_i;

  dot_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .pix     (pix),
    .wgt     (wgt),
    .acc_in  (acc),
    .acc_out (mac_out)
  );

  assign pix_addr_next = PIX_BASE + (ADDR_W'(i) + ADDR_W'(1)) * STRIDE;
  assign wgt_addr      = WGT_BASE + (ADDR_W'(n) * ADDR_W'(VEC_LEN) + ADDR_W'(i)) * STRIDE;
  assign last_i        = (i == I_LAST);
  assign write_n       = 1'b1;
  assign s             = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      read_n       <= 1'b1;
      chipselect   <= 1'b0;
      byteenable   <= '0;
      address      <= '0;
      doneSig      <= 1'b0;
      result       <= '0;
      result_idx   <= '0;
      result_valid <= 1'b0;
      i            <= '0;
      n            <= '0;
      acc          <= '0;
      pix          <= '0;
      wgt          <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          i   <= '0;
          n   <= '0;
          acc <= '0;
          if (startSig) begin
            state      <= S_RD_PIX;
            read_n     <= 1'b0;
            chipselect <= 1'b1;
            byteenable <= '1;
            address    <= PIX_BASE;
          end
        end
        S_RD_PIX: begin
          if (!waitrequest) begin
            state  <= S_WT_PIX;
            read_n <= 1'b1;
          end
        end
        S_WT_PIX: begin
          if (readdatavalid) begin
            pix <= readdata;
`ifdef SKIP_ZERO_EN
            // Zero pixel contributes nothing: advance exactly as the accumulate step would.
            if (readdata == '0) begin
              if (last_i) begin
                state        <= S_EMIT;
                result       <= acc;
                result_idx   <= n;
                result_valid <= 1'b1;
              end else begin
                i       <= i + IW'(1);
                state   <= S_RD_PIX;
                read_n  <= 1'b0;
                address <= pix_addr_next;
              end
            end else begin
              state   <= S_RD_WGT;
              read_n  <= 1'b0;
              address <= wgt_addr;
            end
`else
            state   <= S_RD_WGT;
            read_n  <= 1'b0;
            address <= wgt_addr;
`endif
          end
        end
        S_RD_WGT: begin
          if (!waitrequest) begin
            state  <= S_WT_WGT;
            read_n <= 1'b1;
          end
        end
        S_WT_WGT: begin
          if (readdatavalid) begin
            wgt   <= readdata;
            state <= S_ACC;
          end
        end
        S_ACC: begin
          acc <= mac_out;
          // Result is staged on entry so result_valid is high during the EMIT cycle itself.
          if (last_i) begin
            state        <= S_EMIT;
            result       <= mac_out;
            result_idx   <= n;
            result_valid <= 1'b1;
          end else begin
            i       <= i + IW'(1);
            state   <= S_RD_PIX;
            read_n  <= 1'b0;
            address <= pix_addr_next;
          end
        end
        S_EMIT: begin
          acc <= '0;
          i   <= '0;
          if (n == N_LAST) begin
            state      <= S_DONE;
            doneSig    <= 1'b1;
            chipselect <= 1'b0;
            byteenable <= '0;
          end else begin
            n       <= n + NW'(1);
            state   <= S_RD_PIX;
            read_n  <= 1'b0;
            address <= PIX_BASE;
          end
        end
        S_DONE: begin
          if (!startSig) begin
            state   <= S_IDLE;
            doneSig <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_dot_master.sv
`default_nettype none
// tb_sdram_dot_master: directed plus randomized jobs against a memory-backed Avalon slave and a sum-of-products model.
module tb_sdram_dot_master;

  localparam int          VL   = 4;
  localparam int          NN   = 2;
  localparam logic [31:0] PB   = 32'h0000_0000;
  localparam logic [31:0] WB   = 32'h0400_0000;
`ifdef SKIP_ZERO_EN
  localparam bit          SKIP = 1'b1;
`else
  localparam bit          SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        startSig;
  logic        doneSig;
  logic        read_n;
  logic        write_n;
  logic        chipselect;
  logic [1:0]  byteenable;
  logic [31:0] address;
  logic        waitrequest;
  logic        readdatavalid;
  logic [15:0] readdata;
  logic [39:0] result;
  logic [1:0]  result_idx;
  logic        result_valid;
  logic [3:0]  s;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] pix_mem [VL];
  logic [15:0] wgt_mem [VL*NN];
  logic [39:0] res_q [$];
  logic [1:0]  idx_q [$];
  logic [31:0] addr_q [$];
  int          rv_count = 0;
  int          stall_cfg = 0;
  int          lat_cfg = 0;

  sdram_dot_master #(
    .DATA_W(16), .ADDR_W(32), .VEC_LEN(VL), .NUM_NEURONS(NN), .ACC_W(40),
    .PIX_BASE(PB), .WGT_BASE(WB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .startSig(startSig), .doneSig(doneSig),
    .read_n(read_n), .write_n(write_n), .chipselect(chipselect), .byteenable(byteenable),
    .address(address), .waitrequest(waitrequest), .readdatavalid(readdatavalid),
    .readdata(readdata), .result(result), .result_idx(result_idx),
    .result_valid(result_valid), .s(s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_read(input logic [31:0] a);
    int idx;
    if (a >= WB) begin
      idx = int'((a - WB) >> 1);
      return (idx < VL*NN) ? wgt_mem[idx] : 16'hDEAD;
    end
    idx = int'((a - PB) >> 1);
    return (idx < VL) ? pix_mem[idx] : 16'hBEEF;
  endfunction

  // Avalon slave: optional stall per command, then readdatavalid after a latency.
  initial begin : slave
    int          phase = 0;
    int          ws = 0;
    int          lat = 0;
    logic [31:0] saddr = '0;
    waitrequest   = 1'b0;
    readdatavalid = 1'b0;
    readdata      = '0;
    forever begin
      @(posedge clk); #1;
      readdatavalid = 1'b0;
      waitrequest   = 1'b0;
      if (phase == 2) begin
        lat--;
        if (lat <= 0) begin
          readdatavalid = 1'b1;
          readdata      = mem_read(saddr);
          phase         = 0;
        end
      end else begin
        if (phase == 0 && !read_n && chipselect) begin
          saddr = address;
          ws    = stall_cfg;
          phase = 1;
          addr_q.push_back(address);
        end
        if (phase == 1) begin
          check("cmd_stable", {31'd0, read_n, address}, {31'd0, 1'b0, saddr});
          if (ws > 0) begin
            waitrequest = 1'b1;
            ws--;
          end else begin
            lat   = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 3));
            phase = 2;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (result_valid) begin
      res_q.push_back(result);
      idx_q.push_back(result_idx);
      rv_count++;
    end
  end

  task automatic run_job(input int stall);
    logic [39:0] exp_res [NN];
    logic [31:0] exp_addr [$];
    longint      sum;
    bit          seen;
    int          nreads;
    for (int nn = 0; nn < NN; nn++) begin
      sum = 0;
      for (int k = 0; k < VL; k++) begin
        sum += longint'(pix_mem[k]) * longint'($signed(wgt_mem[nn*VL+k]));
        exp_addr.push_back(PB + 32'(2*k));
        if (!SKIP || pix_mem[k] != 16'h0) exp_addr.push_back(WB + 32'(2*(nn*VL+k)));
      end
      exp_res[nn] = sum[39:0];
    end
    res_q.delete(); idx_q.delete(); addr_q.delete();
    stall_cfg = stall;
    @(negedge clk);
    startSig = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (doneSig) begin seen = 1'b1; break; end
    end
    check("done_reached", {63'd0, seen}, 64'd1);
    check("result_count", 64'(res_q.size()), 64'(NN));
    for (int nn = 0; nn < NN && nn < res_q.size(); nn++) begin
      check("result_value", {24'd0, res_q[nn]}, {24'd0, exp_res[nn]});
      check("result_idx", {62'd0, idx_q[nn]}, 64'(nn));
    end
    nreads = addr_q.size();
    check("addr_count", 64'(nreads), 64'(exp_addr.size()));
    for (int k = 0; k < nreads && k < exp_addr.size(); k++)
      check("addr_seq", {32'd0, addr_q[k]}, {32'd0, exp_addr[k]});
    repeat (5) @(negedge clk);
    check("done_hold_state", {60'd0, s}, 64'd7);
    check("done_hold_flag", {63'd0, doneSig}, 64'd1);
    check("done_no_restart", 64'(addr_q.size()), 64'(nreads));
    startSig = 1'b0;
    repeat (2) @(negedge clk);
    check("back_idle_state", {60'd0, s}, 64'd0);
    check("back_idle_done", {63'd0, doneSig}, 64'd0);
  endtask

  task automatic randomize_data();
    for (int k = 0; k < VL; k++)
      pix_mem[k] = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
    for (int k = 0; k < VL*NN; k++)
      wgt_mem[k] = 16'($urandom);
  endtask

  initial begin
    int rv_before;
    bit hit;
    reset_n  = 1'b0;
    startSig = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("rst_state", {60'd0, s}, 64'd0);
    check("rst_bus", {32'd0, read_n, write_n, chipselect, byteenable, 27'd0}, {32'd0, 1'b1, 1'b1, 1'b0, 2'b00, 27'd0});
    check("rst_address", {32'd0, address}, 64'd0);
    check("rst_outputs", {21'd0, doneSig, result_valid, result_idx, result}, 64'd0);

    // Directed job: results 10 and 7.
    pix_mem = '{16'd1, 16'd2, 16'd3, 16'd4};
    wgt_mem = '{16'd1, 16'd1, 16'd1, 16'd1, 16'hFFFF, 16'd0, 16'd0, 16'd2};
    run_job(0);
    if (res_q.size() == 2) begin
      check("directed_r0", {24'd0, res_q[0]}, 64'd10);
      check("directed_r1", {24'd0, res_q[1]}, 64'd7);
    end

    // Same job with every command stalled 5 cycles.
    run_job(5);
    if (res_q.size() == 2) check("stall_r1", {24'd0, res_q[1]}, 64'd7);

    // Zero-pixel job.
    pix_mem = '{16'd0, 16'd5, 16'd0, 16'd0};
    wgt_mem = '{16'd9, 16'd2, 16'd9, 16'd9, 16'd3, 16'd4, 16'd5, 16'd6};
    run_job(0);
    if (res_q.size() == 2) check("skip_r0", {24'd0, res_q[0]}, 64'd10);
    begin
      int wr = 0;
      foreach (addr_q[k]) if (addr_q[k] >= WB) wr++;
      check("weight_reads", 64'(wr), SKIP ? 64'd2 : 64'd8);
      if (SKIP && addr_q.size() > 2) check("skip_first_wgt_addr", {32'd0, addr_q[2]}, {32'd0, WB + 32'd2});
    end

    // Extreme product: 0xFFFF * -32768.
    pix_mem = '{16'hFFFF, 16'd0, 16'd0, 16'd0};
    wgt_mem = '{16'h8000, 16'd0, 16'd0, 16'd0, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
    run_job(1);
    if (res_q.size() == 2) check("extreme_r0", {24'd0, res_q[0]}, {24'd0, 40'hFF_8000_8000});

    // Randomized jobs.
    for (int j = 0; j < 6; j++) begin
      randomize_data();
      run_job(int'($urandom_range(0, 2)));
    end

    // Reset in WT_WGT with late readdatavalid following it.
    randomize_data();
    pix_mem[0] = 16'd7;
    lat_cfg    = 2;
    stall_cfg  = 0;
    rv_before  = rv_count;
    @(negedge clk);
    startSig = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #2;
      if (s == 4'd4) begin hit = 1'b1; break; end
    end
    check("reached_wt_wgt", {63'd0, hit}, 64'd1);
    reset_n  = 1'b0;
    startSig = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_idle", {60'd0, s}, 64'd0);
    end
    check("post_rst_no_pulse", 64'(rv_count), 64'(rv_before));
    check("post_rst_result", {22'd0, result_idx, result}, 64'd0);
    lat_cfg = 0;
    randomize_data();
    run_job(1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
